cache_wb_controller: RTL
========================

Name: cache_wb_controller

Overview:
- Write-back, write-allocate controller for the 2-way set-associative cache (8 sets, 2-bit tag, 8-bit data) sitting in front of the 32x8 synchronous RAM.
- Serves CPU-side read and write requests through a req/done handshake.
- On a miss it picks the victim way by LRU. A dirty victim is written back to RAM first, then the requested line is filled from RAM.
- This is the RAM-write direction of the cache path: the block that writes to RAM, complementing the RAM-to-cache read mapping.
- Line storage is internal (registers).

Parameters:
- ADDR_W, 5, RAM word address width; tag = ADDR_W-3 bits.
- DATA_W, 8, data word width.
- SETS_LOG2, 3, set index bits (8 sets).

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  1  request strobe; sampled only when busy=0.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address: set index = addr[2:0], tag = addr[4:3].
- wdata  in  DATA_W  write data; sampled with req.
- busy  out  1  high from the cycle after req is accepted until done.
- done  out  1  one-cycle completion pulse.
- hit  out  1  valid with done: 1 = request hit in cache.
- rdata  out  DATA_W  read result, valid with done; holds its value until the next done.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable; a single-cycle pulse.
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency after ram_addr is presented.
- hit_cnt  out  8  hit counter, wraps 255 -> 0.
- miss_cnt  out  8  miss counter, wraps 255 -> 0.

Behaviour:
- Line state, per way per set: valid, dirty, tag[1:0], data[7:0]. One LRU bit per set holds the way to evict next.
- Reset (reset=0, asynchronous):
  - all valid, dirty and LRU bits cleared;
  - state goes to IDLE;
  - busy, done, hit, ram_wren = 0; rdata, ram_addr, ram_wdata, hit_cnt, miss_cnt = 0.
  - Reset mid-operation aborts the request with no done pulse; ram_wren drops immediately.
- IDLE: busy=0. When req=1 at a clock edge, latch we/addr/wdata and go to LOOKUP. req while busy=1 is ignored and not queued.
- LOOKUP (1 cycle): compare the latched tag against both ways of the set.
  - Hit in way w:
    - read: rdata <= data;
    - write: data <= wdata and dirty <= 1;
    - LRU[set] <= ~w; hit_cnt++; go to DONE with hit=1.
  - Miss: miss_cnt++.
    - Victim = first invalid way (way0 preferred if both are invalid), otherwise way LRU[set].
    - Victim valid and dirty -> WRITEBACK; otherwise -> FILL.
- WRITEBACK (1 cycle): ram_wren=1, ram_addr={victim.tag, set}, ram_wdata=victim.data. Then go to FILL.
- FILL (1 cycle): ram_addr={latched tag, set}, ram_wren=0. Then go to FILL_WAIT.
- FILL_WAIT (1 cycle): capture ram_rdata into the victim: valid=1, tag=latched tag, LRU[set] <= ~victim.
  - Read: data=ram_rdata, dirty=0, rdata<=ram_rdata.
  - Write: data=wdata, dirty=1, rdata<=wdata.
  - Then go to DONE with hit=0.
- DONE (1 cycle): done=1 and busy=0; return to IDLE. A new req can be accepted in the DONE cycle.
- Latency, counted as clock edges from req sampled to done high:
  - hit = 2;
  - clean miss = 4;
  - dirty miss = 5.
- ram_wren is high only in WRITEBACK. At most one RAM write per request.
- A write hit never touches RAM. Dirty data reaches RAM only on eviction.
- Both ways valid: the LRU bit alone selects the victim. Both ways valid with the same tag cannot occur and is not handled.
- Counters wrap silently. A single request increments exactly one counter.

Test Plan:
- Reset then read addr=5'h03, RAM[3]=8'hA5 -> ram_wren never 1, done 4 edges after req, hit=0, rdata=A5, miss_cnt=1.
- Repeat read addr=5'h03 -> done after 2 edges, hit=1, rdata=A5, no RAM address change required, hit_cnt=1.
- Write addr=5'h03 wdata=8'h3C (hit), then read 5'h0B and 5'h13 (same set 3, tags 1 and 2) -> the 5'h13 miss evicts way holding tag 0 (LRU). A WRITEBACK cycle shows ram_wren=1, ram_addr=5'h03, ram_wdata=3C; that request has done latency 5.
- Write miss addr=5'h1F wdata=8'h77 to an empty set -> fill from RAM with no writeback; line becomes dirty. A later read hit of 5'h1F returns 77 with hit=1.
- Pulse reset=0 during the FILL_WAIT of a miss -> no done pulse, ram_wren=0. A subsequent read of the same address misses (valid cleared); counters read 0 then 1.
- 256 repeated read hits on one address -> hit_cnt wraps to 0 on the 256th hit and miss_cnt is unchanged.

Source files
------------

// File: rtl/cache_wb_controller.sv
// -----------------------------------------------------------------------------
// cache_wb_controller
//
// Write-back, write-allocate controller for a 2-way set-associative cache
// (8 sets, 2-bit tag, 8-bit data) in front of a 32x8 synchronous RAM.
// Line storage (valid/dirty/tag/data per way, one LRU bit per set) is held in
// registers inside this block.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   req        in   request strobe, sampled while busy=0 (IDLE or DONE cycle)
//   we         in   1 = write, 0 = read, sampled with req
//   addr       in   word address: set = addr[2:0], tag = addr[4:3]
//   wdata      in   write data, sampled with req
//   busy       out  high from the cycle after acceptance until done
//   done       out  one-cycle completion pulse
//   hit        out  valid with done: 1 = request hit
//   rdata      out  read result, valid with done, held until the next done
//   ram_addr   out  RAM address
//   ram_wdata  out  RAM write data
//   ram_wren   out  RAM write enable, high only during WRITEBACK
//   ram_rdata  in   RAM read data, one cycle after ram_addr
//   hit_cnt    out  wrapping hit counter
//   miss_cnt   out  wrapping miss counter
//   dbg_state  out  current FSM state
//
// Handshake: a request is taken on any rising edge where req=1 and busy=0;
// done is asserted for exactly one cycle when it completes, and a new req may
// be presented in that same done cycle. req while busy=1 is dropped.
// -----------------------------------------------------------------------------
module cache_wb_controller #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int SETS_LOG2 = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [7:0]        hit_cnt,
  output logic [7:0]        miss_cnt,
  output logic [2:0]        dbg_state
);

  localparam int TAG_W = ADDR_W - SETS_LOG2;
  localparam int SETS  = 1 << SETS_LOG2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_FILL      = 3'd3;
  localparam logic [2:0] S_FILL_WAIT = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]           state_q, state_d;

  // Latched request
  logic                 we_q;
  logic [TAG_W-1:0]     tag_q;
  logic [SETS_LOG2-1:0] set_q;
  logic [DATA_W-1:0]    wdata_q;

  // Way chosen for replacement on a miss, kept through WRITEBACK/FILL
  logic                 victim_q;

  logic                 hit_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [ADDR_W-1:0]    ram_addr_q;
  logic [DATA_W-1:0]    ram_wdata_q;
  logic                 ram_wren_q;
  logic [7:0]           hit_cnt_q;
  logic [7:0]           miss_cnt_q;

  // Line state; index order is [way][set]
  logic [1:0][SETS-1:0] valid_q;
  logic [1:0][SETS-1:0] dirty_q;
  logic [SETS-1:0]      lru_q;     // way to evict next
  logic [TAG_W-1:0]     tag_mem  [2][SETS];
  logic [DATA_W-1:0]    data_mem [2][SETS];

  // Lookup results for the latched set/tag
  logic                 hit0, hit1, lookup_hit, hit_way;
  logic                 miss_victim, victim_dirty;
  logic                 accept;

  always_comb begin
    hit0         = valid_q[0][set_q] && (tag_mem[0][set_q] == tag_q);
    hit1         = valid_q[1][set_q] && (tag_mem[1][set_q] == tag_q);
    lookup_hit   = hit0 || hit1;
    hit_way      = hit1 && !hit0;
    // First invalid way wins (way0 preferred); otherwise LRU decides.
    if (!valid_q[0][set_q]) begin
      miss_victim = 1'b0;
    end else if (!valid_q[1][set_q]) begin
      miss_victim = 1'b1;
    end else begin
      miss_victim = lru_q[set_q];
    end
    victim_dirty = valid_q[miss_victim][set_q] && dirty_q[miss_victim][set_q];
  end

  assign accept = req && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (req) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (lookup_hit)        state_d = S_DONE;
        else if (victim_dirty) state_d = S_WRITEBACK;
        else                   state_d = S_FILL;
      end
      S_WRITEBACK: state_d = S_FILL;
      S_FILL:      state_d = S_FILL_WAIT;
      S_FILL_WAIT: state_d = S_DONE;
      S_DONE:      state_d = req ? S_LOOKUP : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Control, outputs, counters and the reset-cleared line state bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      tag_q       <= '0;
      set_q       <= '0;
      wdata_q     <= '0;
      victim_q    <= 1'b0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wren_q  <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      lru_q       <= '0;
    end else begin
      state_q    <= state_d;
      ram_wren_q <= 1'b0;

      if (accept) begin
        we_q    <= we;
        tag_q   <= addr[ADDR_W-1:SETS_LOG2];
        set_q   <= addr[SETS_LOG2-1:0];
        wdata_q <= wdata;
      end

      case (state_q)
        S_LOOKUP: begin
          if (lookup_hit) begin
            hit_q          <= 1'b1;
            hit_cnt_q      <= hit_cnt_q + 8'd1;
            lru_q[set_q]   <= ~hit_way;
            if (we_q) begin
              dirty_q[hit_way][set_q] <= 1'b1;
            end else begin
              rdata_q <= data_mem[hit_way][set_q];
            end
          end else begin
            hit_q      <= 1'b0;
            miss_cnt_q <= miss_cnt_q + 8'd1;
            victim_q   <= miss_victim;
            if (victim_dirty) begin
              // Registered so the write is presented during WRITEBACK.
              ram_wren_q  <= 1'b1;
              ram_addr_q  <= {tag_mem[miss_victim][set_q], set_q};
              ram_wdata_q <= data_mem[miss_victim][set_q];
            end else begin
              ram_addr_q <= {tag_q, set_q};
            end
          end
        end
        S_WRITEBACK: begin
          // Fill address must be on the bus for the whole FILL cycle.
          ram_addr_q <= {tag_q, set_q};
        end
        S_FILL_WAIT: begin
          valid_q[victim_q][set_q] <= 1'b1;
          dirty_q[victim_q][set_q] <= we_q;
          lru_q[set_q]             <= ~victim_q;
          rdata_q                  <= we_q ? wdata_q : ram_rdata;
        end
        default: ;
      endcase
    end
  end

  // Tag/data payload; only meaningful where valid is set, so no reset.
  always_ff @(posedge clock) begin
    if ((state_q == S_LOOKUP) && lookup_hit && we_q) begin
      data_mem[hit_way][set_q] <= wdata_q;
    end
    if (state_q == S_FILL_WAIT) begin
      tag_mem[victim_q][set_q]  <= tag_q;
      data_mem[victim_q][set_q] <= we_q ? wdata_q : ram_rdata;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign hit       = hit_q;
  assign rdata     = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wren  = ram_wren_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign dbg_state = state_q;

endmodule
